// File: rtl/dmem_mmio_responder.sv
// -----------------------------------------------------------------------------
// dmem_mmio_responder
//
// Data-memory responder for the processor data port. Word loads and stores
// are served from an internal synchronous RAM. The upper half of the byte
// address space (dmem_addr[15] = 1) is a small MMIO window that holds:
//   0x8000 CYCLE  (RO) free-running 32-bit cycle counter
//   0x8004 TXDATA (WO) push dmem_data_in[7:0] into the transmit FIFO
//   0x8008 STATUS (RO) {count @ [FIFO_AW+8:8], overflow, full, empty}
//   0x800C CLEAR  (WO) any write clears the sticky overflow flag
// The FIFO drains through a valid/ready byte stream toward a console/monitor.
//
// Ports
//   clk            rising-edge clock for all state
//   reset          synchronous, active-high reset
//   dmem_addr      byte address (bits [1:0] ignored)
//   dmem_data_in   store data
//   dmem_wr        1 = store this cycle, 0 = load
//   dmem_data_out  registered load data (1-cycle latency, held on stores)
//   tx_valid       FIFO non-empty
//   tx_data        FIFO head byte
//   tx_ready       consumer accepts the head byte this cycle
// -----------------------------------------------------------------------------
module dmem_mmio_responder #(
  parameter int RAM_AW  = 10,
  parameter int FIFO_AW = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] dmem_addr,
  input  logic [31:0] dmem_data_in,
  input  logic        dmem_wr,
  output logic [31:0] dmem_data_out,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready
);

  localparam int RAM_WORDS  = 1 << RAM_AW;
  localparam int FIFO_DEPTH = 1 << FIFO_AW;

  localparam logic [FIFO_AW:0]   CNT_ONE  = 1;
  localparam logic [FIFO_AW:0]   CNT_FULL = FIFO_DEPTH[FIFO_AW:0];
  localparam logic [FIFO_AW-1:0] PTR_ONE  = 1;

  localparam logic [1:0] REG_CYCLE  = 2'd0;
  localparam logic [1:0] REG_TXDATA = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_CLEAR  = 2'd3;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic              sel_mmio;
  logic [RAM_AW-1:0] ram_idx;
  logic [1:0]        mmio_reg;

  assign sel_mmio = dmem_addr[15];
  assign ram_idx  = dmem_addr[RAM_AW+1:2];
  assign mmio_reg = dmem_addr[3:2];

  // Byte-offset bits and the address bits above the RAM index are ignored on
  // purpose: RAM and the MMIO window both alias across the unused bits.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{dmem_addr[14:RAM_AW+2], dmem_addr[1:0]};

  logic ram_we;
  logic txdata_wr;
  logic clear_wr;

  assign ram_we    = dmem_wr & ~sel_mmio;
  assign txdata_wr = dmem_wr &  sel_mmio & (mmio_reg == REG_TXDATA);
  assign clear_wr  = dmem_wr &  sel_mmio & (mmio_reg == REG_CLEAR);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [31:0]        cycle_q,    cycle_d;
  logic [FIFO_AW-1:0] wr_ptr_q,   wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q,   rd_ptr_d;
  logic [FIFO_AW:0]   count_q,    count_d;
  logic               overflow_q, overflow_d;
  logic [31:0]        rdata_q;

  logic [31:0] ram_mem  [RAM_WORDS];
  logic [7:0]  fifo_mem [FIFO_DEPTH];

  // ---------------------------------------------------------------------------
  // TX FIFO control
  // ---------------------------------------------------------------------------
  logic fifo_empty;
  logic fifo_full;
  logic pop;
  logic push;
  logic drop;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_FULL);

  // A pop needs a byte already present, so a byte pushed into an empty FIFO
  // cannot leave in the same cycle.
  assign pop  = ~fifo_empty & tx_ready;

  // When full, a same-cycle pop frees the slot the push lands in.
  assign push = txdata_wr & (~fifo_full | pop);
  assign drop = txdata_wr &  fifo_full & ~pop;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    // CLEAR and a dropping TXDATA write decode different addresses, so they
    // never collide.
    if (clear_wr) begin
      overflow_d = 1'b0;
    end else if (drop) begin
      overflow_d = 1'b1;
    end
  end

  assign cycle_d = cycle_q + 32'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      cycle_q    <= cycle_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // FIFO storage is never cleared; reset only rewinds pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= dmem_data_in[7:0];
    end
  end

  assign tx_valid = ~fifo_empty;
  assign tx_data  = fifo_mem[rd_ptr_q];

  // ---------------------------------------------------------------------------
  // MMIO read mux (pre-edge state: CYCLE before increment, STATUS before pop)
  // ---------------------------------------------------------------------------
  logic [31:0] status_word;
  logic [31:0] mmio_rdata;

  always_comb begin
    status_word                 = '0;
    status_word[0]              = fifo_empty;
    status_word[1]              = fifo_full;
    status_word[2]              = overflow_q;
    status_word[FIFO_AW+8:8]    = count_q;
  end

  always_comb begin
    mmio_rdata = '0;
    unique case (mmio_reg)
      REG_CYCLE:  mmio_rdata = cycle_q;
      REG_STATUS: mmio_rdata = status_word;
      REG_TXDATA: mmio_rdata = '0;
      REG_CLEAR:  mmio_rdata = '0;
      default:    mmio_rdata = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // RAM and registered load path
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram_mem[ram_idx] <= dmem_data_in;
    end
  end

  // Load data registers only on read cycles, so stores leave it untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (!dmem_wr) begin
      rdata_q <= sel_mmio ? mmio_rdata : ram_mem[ram_idx];
    end
  end

  assign dmem_data_out = rdata_q;

endmodule

// File: tb/tb_dmem_mmio_responder.sv
module tb_dmem_mmio_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] dmem_addr;
  logic [31:0] dmem_data_in;
  logic        dmem_wr;
  logic [31:0] dmem_data_out;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;

  always #5 clk = ~clk;

  dmem_mmio_responder #(.RAM_AW(10), .FIFO_AW(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .dmem_addr    (dmem_addr),
    .dmem_data_in (dmem_data_in),
    .dmem_wr      (dmem_wr),
    .dmem_data_out(dmem_data_out),
    .tx_valid     (tx_valid),
    .tx_data      (tx_data),
    .tx_ready     (tx_ready)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  // Drive one transaction, let one rising edge take it, sample 1 time unit later.
  task automatic step(input logic [15:0] a, input logic [31:0] d, input logic w, input logic r);
    dmem_addr    = a;
    dmem_data_in = d;
    dmem_wr      = w;
    tx_ready     = r;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [15:0] addr;
    logic [31:0] wdata;
    logic        wr;
    logic        rdy;
    logic [31:0] exp_dout;
    logic        exp_valid;
    logic        chk_txd;
    logic [7:0]  exp_txd;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [15:0] a, input logic [31:0] d, input logic w, input logic r,
                     input logic [31:0] ed, input logic ev, input logic ct, input logic [7:0] et,
                     input string n);
    vec_t v;
    v.addr = a; v.wdata = d; v.wr = w; v.rdy = r;
    v.exp_dout = ed; v.exp_valid = ev; v.chk_txd = ct; v.exp_txd = et; v.name = n;
    vecs.push_back(v);
  endtask

  logic [7:0]  drain_exp [0:8];
  logic [31:0] c1, c2;
  logic [7:0]  mq[$];
  int          sent, recv, cyc;
  logic        do_push, rnd_rdy;
  logic [7:0]  push_byte;

  initial begin
    // ---------------- table ----------------
    add(16'h8008, 32'h0,         1'b0, 1'b0, 32'h0000_0001, 1'b0, 1'b0, 8'h00, "status after reset");
    add(16'h0010, 32'hDEADBEEF,  1'b1, 1'b0, 32'h0000_0001, 1'b0, 1'b0, 8'h00, "store 0x0010 holds dout");
    add(16'h0010, 32'h0,         1'b0, 1'b0, 32'hDEADBEEF,  1'b0, 1'b0, 8'h00, "load 0x0010");
    add(16'h1010, 32'h0,         1'b0, 1'b0, 32'hDEADBEEF,  1'b0, 1'b0, 8'h00, "load alias 0x1010");
    add(16'h0014, 32'h12345678,  1'b1, 1'b0, 32'hDEADBEEF,  1'b0, 1'b0, 8'h00, "store 0x0014");
    add(16'h0014, 32'h0,         1'b0, 1'b0, 32'h12345678,  1'b0, 1'b0, 8'h00, "load 0x0014");
    add(16'h8004, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 8'h00, "read TXDATA is 0");
    add(16'h800C, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 8'h00, "read CLEAR is 0");
    add(16'h8008, 32'hFFFFFFFF,  1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 8'h00, "write STATUS ignored");
    add(16'h8008, 32'h0,         1'b0, 1'b0, 32'h0000_0001, 1'b0, 1'b0, 8'h00, "status unchanged");
    add(16'h7FFC, 32'hA5A5A5A5,  1'b1, 1'b0, 32'h0000_0001, 1'b0, 1'b0, 8'h00, "store top word alias");
    add(16'h0FFC, 32'h0,         1'b0, 1'b0, 32'hA5A5A5A5,  1'b0, 1'b0, 8'h00, "load top word");
    add(16'h8108, 32'h0,         1'b0, 1'b0, 32'h0000_0001, 1'b0, 1'b0, 8'h00, "status window alias");
    add(16'h0010, 32'h0,         1'b0, 1'b0, 32'hDEADBEEF,  1'b0, 1'b0, 8'h00, "reload 0x0010");
    for (int b = 8'h41; b <= 8'h48; b++)
      add(16'h8004, 32'(b), 1'b1, 1'b0, 32'hDEADBEEF, 1'b1, 1'b1, 8'h41, "push byte");
    add(16'h8008, 32'h0,         1'b0, 1'b0, 32'h0000_0802, 1'b1, 1'b1, 8'h41, "status full");
    add(16'h8004, 32'h49,        1'b1, 1'b0, 32'h0000_0802, 1'b1, 1'b1, 8'h41, "push while full dropped");
    add(16'h8008, 32'h0,         1'b0, 1'b0, 32'h0000_0806, 1'b1, 1'b1, 8'h41, "status overflow");
    add(16'h800C, 32'h0,         1'b1, 1'b0, 32'h0000_0806, 1'b1, 1'b1, 8'h41, "clear overflow");
    add(16'h8008, 32'h0,         1'b0, 1'b0, 32'h0000_0802, 1'b1, 1'b1, 8'h41, "status cleared");
    add(16'h8004, 32'h50,        1'b1, 1'b1, 32'h0000_0802, 1'b1, 1'b1, 8'h42, "push+pop when full");
    add(16'h8008, 32'h0,         1'b0, 1'b0, 32'h0000_0802, 1'b1, 1'b1, 8'h42, "status still full no ovf");

    drain_exp = '{8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48, 8'h50, 8'h00};

    // ---------------- reset ----------------
    reset = 1'b1;
    dmem_addr = '0; dmem_data_in = '0; dmem_wr = 1'b0; tx_ready = 1'b0;
    step(16'h0000, 32'h0, 1'b0, 1'b0);
    step(16'h0000, 32'h0, 1'b0, 1'b0);
    reset = 1'b0;
    check("reset dout", dmem_data_out, 32'h0);
    check("reset tx_valid", 32'(tx_valid), 32'h0);

    // ---------------- table-driven ----------------
    foreach (vecs[i]) begin
      step(vecs[i].addr, vecs[i].wdata, vecs[i].wr, vecs[i].rdy);
      check({vecs[i].name, " dout"}, dmem_data_out, vecs[i].exp_dout);
      check({vecs[i].name, " valid"}, 32'(tx_valid), 32'(vecs[i].exp_valid));
      if (vecs[i].chk_txd) check({vecs[i].name, " txd"}, 32'(tx_data), 32'(vecs[i].exp_txd));
    end

    // ---------------- drain ----------------
    for (int i = 0; i < 8; i++) begin
      check("drain valid", 32'(tx_valid), 32'h1);
      check("drain data", 32'(tx_data), 32'(drain_exp[i]));
      step(16'h0010, 32'h0, 1'b0, 1'b1);
    end
    check("drained valid", 32'(tx_valid), 32'h0);
    step(16'h8008, 32'h0, 1'b0, 1'b0);
    check("drained status", dmem_data_out, 32'h0000_0001);

    // ---------------- cycle counter ----------------
    step(16'h8000, 32'h0, 1'b0, 1'b0);
    c1 = dmem_data_out;
    repeat (9) step(16'h0010, 32'h0, 1'b0, 1'b0);
    step(16'h8000, 32'h0, 1'b0, 1'b0);
    c2 = dmem_data_out;
    check("cycle delta 10", c2 - c1, 32'd10);
    step(16'h8000, 32'h5555, 1'b1, 1'b0);
    step(16'h8000, 32'h0, 1'b0, 1'b0);
    check("cycle write ignored", dmem_data_out, c2 + 32'd2);

    force dut.cycle_q = 32'hFFFF_FFFF;
    #1;
    release dut.cycle_q;
    step(16'h8000, 32'h0, 1'b0, 1'b0);
    check("cycle max", dmem_data_out, 32'hFFFF_FFFF);
    step(16'h8000, 32'h0, 1'b0, 1'b0);
    check("cycle wrap", dmem_data_out, 32'h0);

    // ---------------- empty push, status during pop ----------------
    step(16'h8004, 32'h70, 1'b1, 1'b1);
    check("empty push valid", 32'(tx_valid), 32'h1);
    check("empty push not popped", 32'(tx_data), 32'h70);
    step(16'h8004, 32'h71, 1'b1, 1'b0);
    check("second push head", 32'(tx_data), 32'h70);
    step(16'h8008, 32'h0, 1'b0, 1'b1);
    check("status pre-pop", dmem_data_out, 32'h0000_0200);
    check("after pop head", 32'(tx_data), 32'h71);
    step(16'h0010, 32'h0, 1'b0, 1'b1);
    check("after last pop valid", 32'(tx_valid), 32'h0);

    // ---------------- reset mid-drain ----------------
    step(16'h8004, 32'h31, 1'b1, 1'b0);
    step(16'h8004, 32'h32, 1'b1, 1'b0);
    step(16'h8004, 32'h33, 1'b1, 1'b0);
    step(16'h0010, 32'h0, 1'b0, 1'b1);
    check("mid-drain head", 32'(tx_data), 32'h32);
    reset = 1'b1;
    step(16'h0010, 32'h0, 1'b0, 1'b1);
    reset = 1'b0;
    check("reset mid valid", 32'(tx_valid), 32'h0);
    check("reset mid dout", dmem_data_out, 32'h0);
    step(16'h8000, 32'h0, 1'b0, 1'b0);
    check("cycle restart", dmem_data_out, 32'h0);
    step(16'h8008, 32'h0, 1'b0, 1'b0);
    check("status after mid reset", dmem_data_out, 32'h0000_0001);
    step(16'h0010, 32'h0, 1'b0, 1'b0);
    check("ram survives reset", dmem_data_out, 32'hDEADBEEF);

    // ---------------- random stream with scoreboard ----------------
    sent = 0; recv = 0; cyc = 0;
    while (recv < 100 && cyc < 3000) begin
      do_push   = (sent < 100) && (mq.size() < 8) && ($urandom_range(0, 3) != 0);
      rnd_rdy   = 1'($urandom_range(0, 1));
      push_byte = 8'((sent * 7 + 3) & 255);
      check("stream valid", 32'(tx_valid), 32'(mq.size() != 0));
      if (mq.size() != 0 && rnd_rdy) begin
        check("stream data", 32'(tx_data), 32'(mq[0]));
        void'(mq.pop_front());
        recv++;
      end
      if (do_push) begin
        mq.push_back(push_byte);
        sent++;
      end
      step(do_push ? 16'h8004 : 16'h0010, 32'(push_byte), do_push, rnd_rdy);
      cyc++;
    end
    check("stream bytes received", 32'(recv), 32'd100);
    step(16'h8008, 32'h0, 1'b0, 1'b0);
    check("stream final status", dmem_data_out, 32'h0000_0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
